// File: rtl/alu_ctrl_pkg.sv
// Shared ALU control encodings: opcode classes, funct codes, control words and FSM states.
// Used by the ALU control unit, the ALU and main control.
package alu_ctrl_pkg;

  localparam logic [2:0] OPC_ADD   = 3'b000;
  localparam logic [2:0] OPC_SUB   = 3'b001;
  localparam logic [2:0] OPC_RTYPE = 3'b010;
  localparam logic [2:0] OPC_AND   = 3'b011;
  localparam logic [2:0] OPC_OR    = 3'b100;
  localparam logic [2:0] OPC_AUX   = 3'b111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_MUL = 6'b011000;
  localparam logic [5:0] FN_DIV = 6'b011010;

  localparam logic [3:0] CTRL_ADD     = 4'b0000;
  localparam logic [3:0] CTRL_SUB     = 4'b0001;
  localparam logic [3:0] CTRL_AND     = 4'b0010;
  localparam logic [3:0] CTRL_OR      = 4'b0011;
  localparam logic [3:0] CTRL_SLT     = 4'b0100;
  localparam logic [3:0] CTRL_AUX     = 4'b0101;
  localparam logic [3:0] CTRL_SLL     = 4'b0110;
  localparam logic [3:0] CTRL_SRL     = 4'b0111;
  localparam logic [3:0] CTRL_MUL     = 4'b1000;
  localparam logic [3:0] CTRL_DIV     = 4'b1001;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_OUT  = 2'b10
  } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Pure combinational decode of (opcode, funct) into the ALU control word plus
// illegal and multicycle qualifiers.
module alu_ctrl_decode #(
  parameter int OPW = 3,
  parameter int FW  = 6,
  parameter int CW  = 4
) (
  input  logic [OPW-1:0] opcode,
  input  logic [FW-1:0]  funct,
  output logic [CW-1:0]  ctrl,
  output logic           illegal,
  output logic           multicycle
);
  import alu_ctrl_pkg::*;

  logic [3:0] code_s;
  logic       illegal_s;
  logic       mc_s;

  // Class decode first; funct only matters for the R-type class
  always_comb begin
    code_s    = CTRL_ILLEGAL;
    illegal_s = 1'b1;
    mc_s      = 1'b0;
    case (opcode)
      OPW'(OPC_ADD): begin code_s = CTRL_ADD; illegal_s = 1'b0; end
      OPW'(OPC_SUB): begin code_s = CTRL_SUB; illegal_s = 1'b0; end
      OPW'(OPC_AND): begin code_s = CTRL_AND; illegal_s = 1'b0; end
      OPW'(OPC_OR):  begin code_s = CTRL_OR;  illegal_s = 1'b0; end
      OPW'(OPC_AUX): begin code_s = CTRL_AUX; illegal_s = 1'b0; end
      OPW'(OPC_RTYPE): begin
        case (funct)
          FW'(FN_ADD): begin code_s = CTRL_ADD; illegal_s = 1'b0; end
          FW'(FN_SUB): begin code_s = CTRL_SUB; illegal_s = 1'b0; end
          FW'(FN_AND): begin code_s = CTRL_AND; illegal_s = 1'b0; end
          FW'(FN_OR):  begin code_s = CTRL_OR;  illegal_s = 1'b0; end
          FW'(FN_SLT): begin code_s = CTRL_SLT; illegal_s = 1'b0; end
          FW'(FN_SLL): begin code_s = CTRL_SLL; illegal_s = 1'b0; end
          FW'(FN_SRL): begin code_s = CTRL_SRL; illegal_s = 1'b0; end
          FW'(FN_MUL): begin code_s = CTRL_MUL; illegal_s = 1'b0; mc_s = 1'b1; end
          FW'(FN_DIV): begin code_s = CTRL_DIV; illegal_s = 1'b0; mc_s = 1'b1; end
          default: begin
            code_s    = CTRL_ILLEGAL;
            illegal_s = 1'b1;
            mc_s      = 1'b0;
          end
        endcase
      end
      default: begin
        code_s    = CTRL_ILLEGAL;
        illegal_s = 1'b1;
        mc_s      = 1'b0;
      end
    endcase
  end

  assign ctrl       = CW'(code_s);
  assign illegal    = illegal_s;
  assign multicycle = mc_s;

endmodule

// File: rtl/alu_control_unit.sv
// Registered, valid/ready ALU control unit: one request per transfer, result one
// cycle later, MUL/DIV held for MC_LAT cycles, illegal requests flagged and counted.
module alu_control_unit #(
  parameter int OPW    = 3,
  parameter int FW     = 6,
  parameter int CW     = 4,
  parameter int MC_LAT = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   ALUOpcode,
  input  logic [FW-1:0]    ALUOperation,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    ALUOutputSignal,
  output logic             out_illegal,
  output logic             out_multicycle,
  output logic             busy,
  output logic [ERR_W-1:0] err_count
);
  import alu_ctrl_pkg::*;

  localparam int CNTW = $clog2(MC_LAT) + 1;
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'((MC_LAT > 1) ? (MC_LAT - 2) : 0);
  localparam logic MC_STALL = (MC_LAT > 1) ? 1'b1 : 1'b0;
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  state_e            state_r;
  state_e            state_nxt_s;
  state_e            launch_state_s;
  logic [CNTW-1:0]   cnt_r;
  logic [CNTW-1:0]   cnt_nxt_s;
  logic [CNTW-1:0]   launch_cnt_s;
  logic [CW-1:0]     dec_ctrl_s;
  logic              dec_illegal_s;
  logic              dec_mc_s;
  logic              in_ready_s;
  logic              accept_s;
  logic [CW-1:0]     ctrl_r;
  logic              illegal_r;
  logic              mc_r;
  logic              out_valid_r;
  logic              busy_r;
  logic [ERR_W-1:0]  err_r;

  alu_ctrl_decode #(
    .OPW (OPW),
    .FW  (FW),
    .CW  (CW)
  ) u_decode (
    .opcode     (ALUOpcode),
    .funct      (ALUOperation),
    .ctrl       (dec_ctrl_s),
    .illegal    (dec_illegal_s),
    .multicycle (dec_mc_s)
  );

  // Ready: open in IDLE, follows the consumer in OUT so single-cycle ops stream
  always_comb begin
    in_ready_s = 1'b0;
    if (reset) begin
      in_ready_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: in_ready_s = 1'b1;
        ST_OUT:  in_ready_s = out_ready;
        default: in_ready_s = 1'b0;
      endcase
    end
  end

  assign accept_s = in_valid && in_ready_s;

  // Where a freshly accepted request goes: straight to OUT, or WAIT for MUL/DIV
  always_comb begin
    launch_state_s = ST_OUT;
    launch_cnt_s   = cnt_r;
    if (dec_mc_s && MC_STALL) begin
      launch_state_s = ST_WAIT;
      launch_cnt_s   = CNT_LOAD;
    end else begin
      launch_state_s = ST_OUT;
      launch_cnt_s   = cnt_r;
    end
  end

  // FSM next-state and latency counter
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = launch_state_s;
          cnt_nxt_s   = launch_cnt_s;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == {CNTW{1'b0}}) begin
          state_nxt_s = ST_OUT;
        end else begin
          cnt_nxt_s = cnt_r - CNTW'(1);
        end
      end
      ST_OUT: begin
        // Accepting in OUT implies out_ready, so consume and launch share the edge
        if (accept_s) begin
          state_nxt_s = launch_state_s;
          cnt_nxt_s   = launch_cnt_s;
        end else if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = {CNTW{1'b0}};
      end
    endcase
  end

  // State, counter and registered status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CNTW{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      out_valid_r <= (state_nxt_s == ST_OUT);
      busy_r      <= (state_nxt_s == ST_WAIT);
    end
  end

  // Result registers load only on acceptance and hold through WAIT and stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r    <= {CW{1'b0}};
      illegal_r <= 1'b0;
      mc_r      <= 1'b0;
    end else if (accept_s) begin
      ctrl_r    <= dec_ctrl_s;
      illegal_r <= dec_illegal_s;
      mc_r      <= dec_mc_s;
    end else begin
      ctrl_r    <= ctrl_r;
      illegal_r <= illegal_r;
      mc_r      <= mc_r;
    end
  end

  // Saturating count of accepted illegal requests
  always_ff @(posedge clk) begin
    if (reset) begin
      err_r <= {ERR_W{1'b0}};
    end else if (accept_s && dec_illegal_s && (err_r != ERR_MAX)) begin
      err_r <= err_r + ERR_W'(1);
    end else begin
      err_r <= err_r;
    end
  end

  assign in_ready        = in_ready_s;
  assign out_valid       = out_valid_r;
  assign busy            = busy_r;
  assign ALUOutputSignal = ctrl_r;
  assign out_illegal     = illegal_r;
  assign out_multicycle  = mc_r;
  assign err_count       = err_r;

endmodule
